mul_seq_32: RTL and testbench
=============================

Name: mul_seq_32

Overview:
- Iterative shift-and-add unsigned multiplier controller that sequences one external, shared 32-bit combinational ripple adder (a, b -> s, carry-out discarded).
- Accepts operand pairs over a valid/ready handshake, steps the adder one partial product per clock, and returns the low 32 bits of the product over a second valid/ready handshake.
- Sits between the execute-stage issue logic and the shared adder instance; it owns the adder inputs whenever it is not idle.

Parameters:
- WIDTH, 32, operand/result/adder width; max RUN iterations equal WIDTH.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  input  1  single clock, all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  operand pair valid.
- in_ready  output  1  high only in IDLE; transfer when in_valid & in_ready.
- op_a  input  WIDTH  multiplicand.
- op_b  input  WIDTH  multiplier.
- out_valid  output  1  result valid (DONE state).
- out_ready  input  1  consumer accepts result.
- result  output  WIDTH  (op_a*op_b) mod 2^WIDTH.
- busy  output  1  high in RUN or DONE.
- add_a  output  WIDTH  to shared adder input a.
- add_b  output  WIDTH  to shared adder input b.
- add_s  input  WIDTH  from shared adder sum s (combinational, same cycle).

Behaviour:
- Reset (async, rst_n=0): state=IDLE; acc, mcand, mplier, cnt, result = 0; out_valid=0, busy=0, in_ready=1 after release. Reset mid-RUN or mid-DONE aborts silently; the pending result is lost.
- Registers: acc, mcand, mplier (all WIDTH), cnt (CNT_W).
- add_a=acc, add_b=mcand in RUN; both 0 in IDLE and DONE (adder inputs quiet when not owned).
- IDLE: in_ready=1. On in_valid: mcand<=op_a, mplier<=op_b, acc<=0, cnt<=0, go RUN. Inputs are not sampled at any other time.
- RUN, one iteration per clock:
  - if mplier[0]: acc<=add_s, else acc holds.
  - mcand<=mcand<<1 (bits shifted past WIDTH are dropped); mplier<=mplier>>1; cnt<=cnt+1.
  - Go DONE when (mplier>>1)==0 or cnt==WIDTH-1; otherwise stay in RUN.
- Early termination: RUN lasts N = max(1, msb_index(op_b)+1) cycles; op_b=0 gives exactly 1 RUN cycle with acc staying 0.
- Latency: accept edge k; out_valid visible after edge k+N; worst case N=WIDTH.
- DONE: out_valid=1, result=acc (registered on RUN->DONE transition), held stable until out_ready. On out_ready, go IDLE, out_valid<=0; result keeps its last value.
- in_valid in RUN/DONE is ignored (in_ready=0). No new accept is allowed in the same cycle as the out handshake; the earliest next accept is the cycle after.
- Arithmetic is modulo 2^WIDTH throughout; adder carry-out is unavailable and not required.

Test Plan:
- Reset, then op_a=3, op_b=5 -> 3 RUN cycles, out_valid after 3 edges past accept, result=15; add_a/add_b=0 in IDLE.
- op_a=0x12345678, op_b=0 -> 1 RUN cycle, result=0; op_a=0, op_b=0xFFFFFFFF -> 32 RUN cycles, result=0.
- op_a=0xFFFFFFFF, op_b=0xFFFFFFFF -> 32 RUN cycles, result=0x00000001; op_a=0x10000, op_b=0x10000 -> result=0 (truncation), N=17.
- Backpressure: result ready with out_ready=0 for 10 cycles while in_valid=1 with new operands -> out_valid, result stable, in_ready=0; new operands not captured until IDLE.
- Reset mid-op: assert rst_n=0 during RUN iteration 5 -> immediately out_valid=0, busy=0, result=0; after release, op_a=7, op_b=6 -> result=42.
- Back-to-back: out_ready tied 1, 20 random pairs -> each result matches (a*b) mod 2^32, one idle cycle between ops, busy never high in IDLE.

Source files
------------

// File: rtl/mul_seq_32_if.sv
// Operand/result handshake bundle between issue logic (master) and the
// sequential multiplier (slave).
interface mul_seq_32_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;

    modport master (
        output in_valid, op_a, op_b, out_ready,
        input  in_ready, out_valid, result
    );

    modport slave (
        input  in_valid, op_a, op_b, out_ready,
        output in_ready, out_valid, result
    );
endinterface

// File: rtl/mul_seq_32.sv
// Shift-and-add unsigned multiplier that borrows a shared external adder,
// one partial product per clock, returning the low WIDTH bits of the product.
module mul_seq_32 #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    mul_seq_32_if.slave      bus,
    output logic             busy,
    output logic [WIDTH-1:0] add_a,
    output logic [WIDTH-1:0] add_b,
    input  logic [WIDTH-1:0] add_s
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t             state_q;
    state_t             state_d;
    logic [WIDTH-1:0]   acc;
    logic [WIDTH-1:0]   mcand;
    logic [WIDTH-1:0]   mplier;
    logic [CNT_W-1:0]   cnt;
    logic [WIDTH-1:0]   result_q;
    logic [WIDTH-1:0]   acc_next;
    logic               last_iter;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        // NOTE: every signal driven here gets a default first, so no branch can infer a latch.
        state_d       = state_q;
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        busy          = 1'b0;
        add_a         = '0;
        add_b         = '0;
        // Stop once no set multiplier bits remain above bit 0, or after WIDTH steps.
        last_iter     = ((mplier >> 1) == '0) || (cnt == CNT_W'(WIDTH - 1));
        acc_next      = mplier[0] ? add_s : acc;

        case (state_q)
            S_IDLE: begin
                bus.in_ready = 1'b1;
                if (bus.in_valid) state_d = S_RUN;
            end
            S_RUN: begin
                busy  = 1'b1;
                add_a = acc;
                add_b = mcand;
                if (last_iter) state_d = S_DONE;
            end
            S_DONE: begin
                busy          = 1'b1;
                bus.out_valid = 1'b1;
                if (bus.out_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the datapath is cleared on reset so an aborted product never leaks onto result.
            acc      <= '0;
            mcand    <= '0;
            mplier   <= '0;
            cnt      <= '0;
            result_q <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.in_valid) begin
                        mcand  <= bus.op_a;
                        mplier <= bus.op_b;
                        acc    <= '0;
                        cnt    <= '0;
                    end
                end
                S_RUN: begin
                    acc    <= acc_next;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + 1'b1;
                    if (last_iter) result_q <= acc_next;
                end
                default: ;
            endcase
        end
    end

    assign bus.result = result_q;

endmodule

// File: tb/tb_mul_seq_32.sv
// Self-checking bench for mul_seq_32: scoreboard of expected products, latency
// checks against the early-termination rule, backpressure, reset abort and streaming.
module tb_mul_seq_32;

    logic        clk;
    logic        rst_n;
    logic        busy;
    logic [31:0] add_a;
    logic [31:0] add_b;
    logic [31:0] add_s;

    int          vectors;
    int          miscompares;
    logic [31:0] exp_q[$];

    mul_seq_32_if #(.WIDTH(32)) bus ();

    mul_seq_32 #(.WIDTH(32), .CNT_W(6)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus),
        .busy  (busy),
        .add_a (add_a),
        .add_b (add_b),
        .add_s (add_s)
    );

    // Shared combinational adder, carry-out discarded.
    assign add_s = add_a + add_b;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic int exp_cycles(input logic [31:0] b);
        int n;
        n = 1;
        for (int i = 0; i < 32; i++) if (b[i]) n = i + 1;
        return n;
    endfunction

    // Drives one operand pair from IDLE, waits for the result and retires it.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b);
        int          n;
        int          exp_n;
        logic [31:0] prod;
        logic [31:0] exp_r;
        bus.op_a      = a;
        bus.op_b      = b;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b0;
        vectors++;
        if (bus.in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL in_ready_idle: got %b expected 1", bus.in_ready);
        end
        tick;
        prod = a * b;
        exp_q.push_back(prod);
        bus.in_valid = 1'b0;
        vectors++;
        if (busy !== 1'b1 || bus.in_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL run_flags: got busy=%b in_ready=%b expected busy=1 in_ready=0", busy, bus.in_ready);
        end
        exp_n = exp_cycles(b);
        n = 0;
        while (bus.out_valid !== 1'b1 && n < 64) begin
            tick;
            n++;
        end
        vectors++;
        if (n !== exp_n) begin
            miscompares++;
            $display("FAIL latency a=%h b=%h: got %0d edges expected %0d", a, b, n, exp_n);
        end
        exp_r = exp_q.pop_front();
        vectors++;
        if (bus.result !== exp_r) begin
            miscompares++;
            $display("FAIL result a=%h b=%h: got %h expected %h", a, b, bus.result, exp_r);
        end
        bus.out_ready = 1'b1;
        tick;
        bus.out_ready = 1'b0;
        vectors++;
        if (bus.out_valid !== 1'b0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL retire: got out_valid=%b busy=%b expected 0/0", bus.out_valid, busy);
        end
    endtask

    task automatic test_reset;
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.op_a      = '0;
        bus.op_b      = '0;
        bus.out_ready = 1'b0;
        #3;
        vectors++;
        if (bus.out_valid !== 1'b0 || busy !== 1'b0 || bus.result !== 32'h0) begin
            miscompares++;
            $display("FAIL reset_state: got out_valid=%b busy=%b result=%h expected 0/0/0", bus.out_valid, busy, bus.result);
        end
        tick;
        tick;
        rst_n = 1'b1;
        #1;
        vectors++;
        if (bus.in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_in_ready: got %b expected 1", bus.in_ready);
        end
    endtask

    task automatic test_basic;
        vectors++;
        if (add_a !== 32'h0 || add_b !== 32'h0) begin
            miscompares++;
            $display("FAIL idle_adder: got add_a=%h add_b=%h expected 0/0", add_a, add_b);
        end
        run_op(32'd3, 32'd5);
        vectors++;
        if (add_a !== 32'h0 || add_b !== 32'h0) begin
            miscompares++;
            $display("FAIL idle_adder_after: got add_a=%h add_b=%h expected 0/0", add_a, add_b);
        end
    endtask

    task automatic test_early_term;
        run_op(32'h1234_5678, 32'h0000_0000);
        run_op(32'h0000_0000, 32'hFFFF_FFFF);
        run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run_op(32'h0001_0000, 32'h0001_0000);
    endtask

    task automatic test_backpressure;
        int          n;
        logic [31:0] prod;
        logic [31:0] exp_r;
        bus.op_a     = 32'd3;
        bus.op_b     = 32'd4;
        bus.in_valid = 1'b1;
        tick;
        prod = 32'd12;
        exp_q.push_back(prod);
        bus.in_valid = 1'b0;
        n = 0;
        while (bus.out_valid !== 1'b1 && n < 64) begin
            tick;
            n++;
        end
        vectors++;
        if (n !== 3) begin
            miscompares++;
            $display("FAIL bp_latency: got %0d edges expected 3", n);
        end
        bus.op_a     = 32'd9;
        bus.op_b     = 32'd9;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            vectors++;
            if (bus.out_valid !== 1'b1 || bus.result !== exp_q[0] || bus.in_ready !== 1'b0 ||
                add_a !== 32'h0 || add_b !== 32'h0) begin
                miscompares++;
                $display("FAIL bp_hold cycle %0d: got out_valid=%b result=%h in_ready=%b add_a=%h add_b=%h expected 1/%h/0/0/0",
                         i, bus.out_valid, bus.result, bus.in_ready, add_a, add_b, exp_q[0]);
            end
            tick;
        end
        exp_r = exp_q.pop_front();
        vectors++;
        if (bus.result !== exp_r) begin
            miscompares++;
            $display("FAIL bp_result: got %h expected %h", bus.result, exp_r);
        end
        bus.out_ready = 1'b1;
        tick;
        bus.out_ready = 1'b0;
        vectors++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL bp_release: got out_valid=%b in_ready=%b expected 0/1", bus.out_valid, bus.in_ready);
        end
        run_op(32'd9, 32'd9);
    endtask

    task automatic test_reset_mid_op;
        logic [31:0] prod;
        bus.op_a     = 32'd5;
        bus.op_b     = 32'h0000_FFFF;
        bus.in_valid = 1'b1;
        tick;
        prod = 32'd5 * 32'h0000_FFFF;
        exp_q.push_back(prod);
        bus.in_valid = 1'b0;
        for (int i = 0; i < 4; i++) tick;
        vectors++;
        if (busy !== 1'b1 || bus.out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL pre_abort: got busy=%b out_valid=%b expected 1/0", busy, bus.out_valid);
        end
        rst_n = 1'b0;
        #1;
        vectors++;
        if (bus.out_valid !== 1'b0 || busy !== 1'b0 || bus.result !== 32'h0) begin
            miscompares++;
            $display("FAIL abort: got out_valid=%b busy=%b result=%h expected 0/0/0", bus.out_valid, busy, bus.result);
        end
        exp_q.delete();
        #1;
        rst_n = 1'b1;
        tick;
        run_op(32'd7, 32'd6);
    endtask

    task automatic test_back_to_back;
        int          n;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] prod;
        logic [31:0] exp_r;
        bus.out_ready = 1'b1;
        for (int k = 0; k < 20; k++) begin
            a = $urandom;
            b = (k % 4 == 0) ? ($urandom >> $urandom_range(0, 31)) : $urandom;
            bus.op_a     = a;
            bus.op_b     = b;
            bus.in_valid = 1'b1;
            vectors++;
            if (bus.in_ready !== 1'b1 || busy !== 1'b0) begin
                miscompares++;
                $display("FAIL b2b_idle op %0d: got in_ready=%b busy=%b expected 1/0", k, bus.in_ready, busy);
            end
            tick;
            prod = a * b;
            exp_q.push_back(prod);
            n = 0;
            while (bus.out_valid !== 1'b1 && n < 64) begin
                tick;
                n++;
            end
            exp_r = exp_q.pop_front();
            vectors++;
            if (bus.result !== exp_r || n !== exp_cycles(b)) begin
                miscompares++;
                $display("FAIL b2b op %0d a=%h b=%h: got result=%h after %0d edges expected %h after %0d",
                         k, a, b, bus.result, n, exp_r, exp_cycles(b));
            end
            tick;
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        vectors++;
        if (busy !== 1'b0 || bus.in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL b2b_end: got busy=%b in_ready=%b expected 0/1", busy, bus.in_ready);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        test_reset;
        test_basic;
        test_early_term;
        test_backpressure;
        test_reset_mid_op;
        test_back_to_back;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
